// File: rtl/gcd_stein_core.sv
// gcd_stein_core: binary (Stein) GCD engine with valid/ready handshakes on
// the operand and result sides. Only shifts and subtracts are used, no dividers.
// Optional build macro GCD_CYCLE_COUNT_EN adds cycles_o. It reports the number of
// STRIP+CALC cycles spent on the current result.
module gcd_stein_core #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(3*DATA_WIDTH+4)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  cycles_o
`endif
);

    typedef enum logic [1:0] {IDLE, STRIP, CALC, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a, b;
    logic [CNT_WIDTH-1:0]  k;   // common power of two stripped from both operands

    logic accept;
    assign accept = (state == IDLE) && in_valid_i && in_ready_o;

    // Main FSM: handshakes, strip common factors of two, then reduce odd pair.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            k           <= '0;
            gcd_o       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a          <= operand_a_i;
                        b          <= operand_b_i;
                        k          <= '0;
                        in_ready_o <= 1'b0;
                        if (operand_a_i == '0 || operand_b_i == '0) begin
                            // gcd(x,0)=x and gcd(0,0)=0, so a|b covers all cases
                            gcd_o       <= operand_a_i | operand_b_i;
                            out_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy_o <= 1'b1;
                            state  <= STRIP;
                        end
                    end
                end
                STRIP: begin
                    if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + CNT_WIDTH'(1);
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a == b) begin
                        // result divides both operands, so the shift cannot overflow
                        gcd_o       <= a << k;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else if (a > b) begin
                        a <= (a - b) >> 1;   // odd - odd is even
                    end else begin
                        b <= (b - a) >> 1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    // Cycle counter: cleared on accept, counts STRIP/CALC cycles, holds otherwise.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cycles_o <= '0;
        end else if (accept) begin
            cycles_o <= '0;
        end else if (state == STRIP || state == CALC) begin
            cycles_o <= cycles_o + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
